ram_stream_ctrl: RTL and testbench
==================================

RAM_STREAM_CTRL -- requirements
Module: ram_stream_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width; depth = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 8, RAM/UART byte width.
REQ-003 Parameter FILL_SEED, default 8'h00, value written to address 0 during fill.
REQ-004 clk  in  1  system clock; one clock; reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 fill_req  in  1  one-cycle pulse (debounced key), start RAM fill.
REQ-007 dump_req  in  1  one-cycle pulse (debounced key), start RAM-to-UART dump.
REQ-008 abort  in  1  one-cycle pulse, cancel the current operation.
REQ-009 ram_we  out  1  RAM write enable.
REQ-010 ram_addr  out  ADDR_W  RAM address.
REQ-011 ram_din  out  DATA_W  RAM write data.
REQ-012 ram_dout  in  DATA_W  RAM read data, valid 1 clk after ram_addr is presented.
REQ-013 tx_data  out  DATA_W  byte to the UART transmitter.
REQ-014 tx_send  out  1  one-cycle send pulse to the UART transmitter.
REQ-015 tx_done  in  1  one-cycle pulse from the UART when the byte is finished.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 op_done  out  1  one-cycle pulse when a fill or dump completes normally.

Function
REQ-018 FSM states SHALL be IDLE, FILL, RD_ADDR, RD_WAIT, SEND, WAIT_DONE.
REQ-019 IDLE: fill_req -> FILL with addr=0; dump_req -> RD_ADDR with addr=0; both in the same cycle -> FILL wins and dump_req is dropped.
REQ-020 FILL: ram_we=1 every cycle, ram_din = FILL_SEED + ram_addr (mod 2**DATA_W), addr increments by 1 per cycle; a full fill takes 2**ADDR_W cycles.
REQ-021 FILL at the last address (all ones) SHALL write that address, pulse op_done in that same cycle, and enter IDLE next; the address SHALL NOT wrap into a second pass.
REQ-022 RD_ADDR: present ram_addr with ram_we=0, then go to RD_WAIT.
REQ-023 RD_WAIT: wait one cycle for the RAM read latency, then go to SEND.
REQ-024 SEND: latch ram_dout into tx_data, assert tx_send for exactly 1 cycle, then go to WAIT_DONE.
REQ-025 WAIT_DONE: hold tx_data stable; on tx_done go to RD_ADDR with addr+1; on tx_done at the last address, pulse op_done and go to IDLE.
REQ-026 Dump latency SHALL be: 3 clk from dump_req to the first tx_send, and 3 clk from each tx_done to the next tx_send.
REQ-027 fill_req and dump_req SHALL be ignored while busy=1.
REQ-028 tx_done SHALL be ignored outside WAIT_DONE.
REQ-029 abort in any non-IDLE state SHALL force IDLE on the next edge, with ram_we=0 and tx_send=0 from that edge on, no op_done, and no further RAM writes; abort in IDLE has no effect.
REQ-030 ram_we SHALL be high only in FILL; tx_send SHALL be high only for the one SEND cycle.

Reset
REQ-031 rst=1 at any clock edge, including mid-fill or mid-dump, SHALL force: state IDLE, ram_addr=0, ram_din=0, ram_we=0, tx_data=0, tx_send=0, busy=0, op_done=0.
REQ-032 rst SHALL take priority over abort, fill_req and dump_req.

Structure
REQ-033 The state encoding and the default ADDR_W/DATA_W constants SHALL live in the shared package ram_stream_pkg.
REQ-034 The block is a single module with no sub-modules; the address counter and the FSM are local to it.

Verification
REQ-035 fill_req with FILL_SEED=8'h00 -> 256 consecutive cycles of ram_we=1, addr 0..255 with data 0..255, one op_done at addr 255, then busy=0.
REQ-036 Fill, then dump_req with the UART model returning tx_done 10 clk after each tx_send -> 256 tx_send pulses carrying 0x00..0xFF in order, first tx_send 3 clk after dump_req, op_done after the 256th tx_done.
REQ-037 fill_req and dump_req asserted in the same cycle -> FILL runs, and no tx_send occurs before op_done.
REQ-038 abort at dump byte 5 (state WAIT_DONE) -> IDLE next cycle; a late tx_done is ignored; a new dump restarts at addr 0 with byte 0x00.
REQ-039 rst during FILL at addr 100 -> all outputs 0 on the next edge and RAM addresses 101..255 stay unwritten; a spurious tx_done in IDLE produces no output change.
REQ-040 dump_req pulsed during FILL -> ignored; the fill completes normally and no dump follows.

Source files
------------

// File: rtl/ram_stream_pkg.sv
// Shared constants and FSM encoding for the RAM fill / RAM-to-UART dump controller.
package ram_stream_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_RD_ADDR   = 3'd2,
        ST_RD_WAIT   = 3'd3,
        ST_SEND      = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/ram_stream_ctrl.sv
// Fills a RAM with an incrementing pattern, or streams its contents byte by byte
// to a UART transmitter. All outputs are registered; one FSM owns the address counter.
module ram_stream_ctrl
    import ram_stream_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] FILL_SEED = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_req,
    input  logic              dump_req,
    input  logic              abort,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_send,
    input  logic              tx_done,
    output logic              busy,
    output logic              op_done
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_we;
    logic              r_tx_send;
    logic              r_op_done;

    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_last;

    assign w_addr_nxt = r_addr + ADDR_W'(1);
    assign w_last     = (r_addr == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_din     <= '0;
            r_tx_data <= '0;
            r_we      <= 1'b0;
            r_tx_send <= 1'b0;
            r_op_done <= 1'b0;
        end else if (abort && r_state != ST_IDLE) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_tx_send <= 1'b0;
            r_op_done <= 1'b0;
        end else begin
            r_op_done <= 1'b0;
            r_tx_send <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Fill takes precedence; a simultaneous dump request is dropped.
                    if (fill_req) begin
                        r_state <= ST_FILL;
                        r_addr  <= '0;
                        r_din   <= FILL_SEED;
                        r_we    <= 1'b1;
                    end else if (dump_req) begin
                        r_state <= ST_RD_ADDR;
                        r_addr  <= '0;
                    end
                end
                ST_FILL: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_we    <= 1'b0;
                    end else begin
                        r_addr    <= w_addr_nxt;
                        r_din     <= FILL_SEED + DATA_W'(w_addr_nxt);
                        // op_done coincides with the write to the final address.
                        r_op_done <= (w_addr_nxt == LAST);
                    end
                end
                ST_RD_ADDR: r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    r_tx_data <= ram_dout;
                    r_tx_send <= 1'b1;
                    r_state   <= ST_SEND;
                end
                ST_SEND: r_state <= ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        if (w_last) begin
                            r_op_done <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_addr  <= w_addr_nxt;
                            r_state <= ST_RD_ADDR;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ram_we   = r_we;
    assign ram_addr = r_addr;
    assign ram_din  = r_din;
    assign tx_data  = r_tx_data;
    assign tx_send  = r_tx_send;
    assign op_done  = r_op_done;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Scoreboard bench: expected RAM writes and UART bytes are queued at stimulus time
// and popped by a negedge monitor; a RAM model and a 10-cycle UART model close the loop.
module tb_ram_stream_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fill_req = 1'b0;
    logic          dump_req = 1'b0;
    logic          abort = 1'b0;
    logic          tb_done = 1'b0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [DW-1:0] tx_data;
    logic          tx_send;
    logic          tx_done;
    logic          busy;
    logic          op_done;

    logic [DW-1:0] mem [DEPTH];
    bit            wflag [DEPTH];
    int            ucnt = 0;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            wr_cnt = 0;
    int            tx_cnt = 0;
    int            done_cnt = 0;
    bit            lat_arm = 1'b0;
    int            done_cyc = 0;
    logic [31:0]   wq [$];
    logic [31:0]   tq [$];

    ram_stream_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FILL_SEED(8'h00)) dut (
        .clk      (clk),
        .rst      (rst),
        .fill_req (fill_req),
        .dump_req (dump_req),
        .abort    (abort),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_done  (tx_done),
        .busy     (busy),
        .op_done  (op_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_we === 1'b1) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    // UART model: tx_done pulses 10 cycles after each tx_send.
    always @(posedge clk) begin
        if (tx_send === 1'b1) ucnt <= 10;
        else if (ucnt > 0)    ucnt <= ucnt - 1;
    end
    assign tx_done = (ucnt == 1) || tb_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_cnt++;
            wflag[ram_addr] = 1'b1;
            if (wq.size() == 0) chk("wr_unexp", {16'h0, ram_addr, ram_din}, 32'hFFFF_FFFF);
            else                chk("wr", {16'h0, ram_addr, ram_din}, wq.pop_front());
        end
        if (tx_send === 1'b1) begin
            tx_cnt++;
            if (tq.size() == 0) chk("tx_unexp", 32'(tx_data), 32'h1FF);
            else                chk("tx", 32'(tx_data), tq.pop_front());
            if (lat_arm) begin
                chk("lat_nxt", 32'(cyc - done_cyc), 32'd3);
                lat_arm = 1'b0;
            end
        end
        if (busy !== 1'b1) lat_arm = 1'b0;
        if (tx_done === 1'b1 && busy === 1'b1) begin
            lat_arm  = 1'b1;
            done_cyc = cyc;
        end
        if (op_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (op_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_fill(input int last);
        for (int i = 0; i <= last; i++) wq.push_back({16'h0, 8'(i), 8'(i)});
    endtask

    task automatic pulse_dump_lat(input string tag);
        int n;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        n = 1;
        while (tx_send !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'd3);
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {10'h0, busy, tx_send, ram_we, op_done, ram_addr, ram_din, tx_data}, 32'h0);
    endtask

    initial begin
        bit ok;
        int b, d, n;

        repeat (3) tick();
        chk_zero("reset_outs");
        rst = 1'b0;
        tick();

        // Full fill
        push_fill(255);
        b = wr_cnt; d = done_cnt;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        chk("fill_first", 32'({ram_we, ram_addr}), {23'h0, 1'b1, 8'h00});
        wait_done(300, ok);
        chk("fill_done_seen", 32'(ok), 32'd1);
        chk("fill_done_addr", 32'({ram_we, ram_addr}), {23'h0, 1'b1, 8'hFF});
        tick();
        chk("fill_idle", 32'({busy, ram_we}), 32'd0);
        chk("fill_wr_cnt", 32'(wr_cnt - b), 32'd256);
        chk("fill_done_cnt", 32'(done_cnt - d), 32'd1);
        chk("fill_wq_empty", 32'(wq.size()), 32'd0);

        // Full dump
        for (int i = 0; i < 256; i++) tq.push_back(32'(i));
        b = tx_cnt;
        pulse_dump_lat("dump_lat_first");
        wait_done(256 * 15, ok);
        chk("dump_done_seen", 32'(ok), 32'd1);
        chk("dump_done_after_txd", 32'(cyc - done_cyc), 32'd1);
        chk("dump_tx_cnt", 32'(tx_cnt - b), 32'd256);
        chk("dump_tq_empty", 32'(tq.size()), 32'd0);
        tick();
        chk("dump_idle", 32'(busy), 32'd0);

        // Simultaneous fill and dump: fill wins
        push_fill(255);
        b = tx_cnt;
        fill_req = 1'b1; dump_req = 1'b1;
        tick();
        fill_req = 1'b0; dump_req = 1'b0;
        chk("both_fill_we", 32'(ram_we), 32'd1);
        wait_done(300, ok);
        chk("both_done_seen", 32'(ok), 32'd1);
        repeat (5) tick();
        chk("both_no_tx", 32'(tx_cnt - b), 32'd0);
        chk("both_idle", 32'(busy), 32'd0);

        // Abort at byte 5 in WAIT_DONE, late tx_done ignored
        for (int i = 0; i < 6; i++) tq.push_back(32'(i));
        b = tx_cnt; d = done_cnt;
        pulse_dump_lat("abort_lat_first");
        for (int i = 0; i < 200 && (tx_cnt - b) < 6; i++) tick();
        chk("abort_reach", 32'(tx_cnt - b), 32'd6);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_outs", 32'({busy, tx_send, ram_we}), 32'd0);
        repeat (15) tick();
        chk("abort_stay_idle", 32'({busy, tx_send, ram_we}), 32'd0);
        chk("abort_no_more_tx", 32'(tx_cnt - b), 32'd6);
        chk("abort_no_done", 32'(done_cnt - d), 32'd0);
        tq.push_back(32'h00);
        b = tx_cnt;
        pulse_dump_lat("restart_lat");
        tick();
        chk("restart_one_tx", 32'(tx_cnt - b), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (15) tick();
        chk("restart_tq_empty", 32'(tq.size()), 32'd0);

        // Reset mid-fill at address 100
        for (int i = 0; i < DEPTH; i++) wflag[i] = 1'b0;
        push_fill(100);
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        for (int i = 0; i < 200 && ram_addr != 8'd100; i++) tick();
        chk("rst_reach_100", 32'(ram_addr), 32'd100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst_mid_fill");
        repeat (300) tick();
        n = 0;
        for (int i = 101; i < DEPTH; i++) if (wflag[i]) n++;
        chk("rst_unwritten", 32'(n), 32'd0);
        chk("rst_wq_empty", 32'(wq.size()), 32'd0);
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        tick();
        chk_zero("spurious_txd");

        // Dump request during fill is ignored
        push_fill(255);
        b = tx_cnt;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        repeat (10) tick();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        wait_done(300, ok);
        chk("dif_done_seen", 32'(ok), 32'd1);
        repeat (10) tick();
        chk("dif_no_tx", 32'(tx_cnt - b), 32'd0);
        chk("dif_idle", 32'(busy), 32'd0);
        chk("dif_wq_empty", 32'(wq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
